// File: rtl/receiver_mul_pipe_if.sv
// receiver_mul_pipe_if -- operand/result handshake bundle for receiver_mul_pipe.
//
// Handshake rules: a transfer happens on a rising clock edge only when valid
// and ready are both high in the cycle before that edge. The producer raises
// valid with stable data and keeps both unchanged until the transfer. Ready
// may depend combinationally on the consumer's state. On the input side
// in_valid/in_ready carry din0/din1. On the output side out_valid/out_ready
// carry dout/out_sat.
interface receiver_mul_pipe_if #(
  parameter int din0_WIDTH = 18,
  parameter int din1_WIDTH = 17,
  parameter int dout_WIDTH = 34
) ();

  logic signed [din0_WIDTH-1:0] din0;
  logic signed [din1_WIDTH-1:0] din1;
  logic                         in_valid;
  logic                         in_ready;
  logic signed [dout_WIDTH-1:0] dout;
  logic                         out_sat;
  logic                         out_valid;
  logic                         out_ready;

  // Upstream source / downstream sink side, as seen by a testbench or wrapper
  modport master (
    output din0, din1, in_valid, out_ready,
    input  in_ready, dout, out_sat, out_valid
  );

  // Multiplier side
  modport slave (
    input  din0, din1, in_valid, out_ready,
    output in_ready, dout, out_sat, out_valid
  );

endinterface

// File: rtl/receiver_mul_pipe.sv
// receiver_mul_pipe -- pipelined signed multiplier with optional rounded
// arithmetic right shift and narrowing to dout_WIDTH.
//
// Stage 1 registers the exact product. Middle stages only delay it. The last
// stage registers the rounded and narrowed result. With NUM_STAGE = 1 the
// whole datapath feeds that single register combinationally.
//
// Every stage has its own valid bit. A stage loads when it is empty or when
// its content moves on. Bubbles therefore collapse even while the output is
// stalled.
//
// Optional feature macro: RECEIVER_MUL_SAT_EN.
//   When defined, results outside the dout range are clipped and out_sat
//   flags them.
//   When undefined, results wrap to dout_WIDTH bits and out_sat is 0.
module receiver_mul_pipe #(
  parameter int din0_WIDTH = 18,
  parameter int din1_WIDTH = 17,
  parameter int dout_WIDTH = 34,
  parameter int NUM_STAGE  = 2,
  parameter int SHIFT      = 0
) (
  input logic                ap_clk,
  input logic                ap_rst,
  receiver_mul_pipe_if.slave mul_if
);

  localparam int PW = din0_WIDTH + din1_WIDTH;  // exact product width
  localparam int RW = PW + 1;                   // rounding headroom
  localparam int XW = (RW > dout_WIDTH) ? RW : dout_WIDTH + 1;

  logic [NUM_STAGE-1:0]  v_q;
  logic [NUM_STAGE-1:0]  v_d;
  logic [NUM_STAGE-1:0]  v_in;
  logic [NUM_STAGE-1:0]  load;
  logic signed [PW-1:0]  a_ext;
  logic signed [PW-1:0]  b_ext;
  logic signed [PW-1:0]  prod;
  logic signed [PW-1:0]  nar_in;
  logic signed [RW-1:0]  r_full;
  logic signed [XW-1:0]  r_ext;
  logic [dout_WIDTH-1:0] nar_d;
  logic [dout_WIDTH-1:0] dout_q;
  logic [dout_WIDTH-1:0] dout_d;
  logic                  out_ld;

  // Exact signed product: both operands are sign-extended to the full width first.
  assign a_ext = PW'(mul_if.din0);
  assign b_ext = PW'(mul_if.din1);
  assign prod  = a_ext * b_ext;

  // Ready chain from the output back to the input.
  // A stage may load when it is empty or when everything downstream of it moves.
  always_comb begin : ready_chain
    logic r;
    r = mul_if.out_ready;
    for (int k = NUM_STAGE - 1; k >= 0; k--) begin
      r       = ~v_q[k] | r;
      load[k] = r;
    end
  end

  // Valid bit offered to each stage by its upstream neighbour
  always_comb begin
    v_in[0] = mul_if.in_valid;
    for (int k = 1; k < NUM_STAGE; k++) begin
      v_in[k] = v_q[k-1];
    end
  end

  // Next-state valid: a loading stage takes its upstream valid, otherwise it holds
  always_comb begin
    v_d = v_q;
    for (int k = 0; k < NUM_STAGE; k++) begin
      if (load[k]) begin
        v_d[k] = v_in[k];
      end
    end
  end

  // Stage valid registers; reset discards everything in flight
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      v_q <= '0;
    end else begin
      v_q <= v_d;
    end
  end

  // Stage 1 captures the product and middle stages delay it.
  // A single-stage build has no product register at all.
  generate
    if (NUM_STAGE == 1) begin : g_comb
      assign nar_in = prod;
    end else begin : g_pipe
      logic signed [PW-1:0] p_q [NUM_STAGE-1];

      // Product delay line; a stage only captures real data, never bubbles
      always_ff @(posedge ap_clk) begin
        if (load[0] && v_in[0]) begin
          p_q[0] <= prod;
        end
        for (int k = 1; k < NUM_STAGE - 1; k++) begin
          if (load[k] && v_in[k]) begin
            p_q[k] <= p_q[k-1];
          end
        end
      end

      assign nar_in = p_q[NUM_STAGE-2];
    end
  endgenerate

  // Rounding: add half an LSB of the shifted result, then shift arithmetically.
  // The extra top bit keeps the add from overflowing, and ties round toward +inf.
  generate
    if (SHIFT == 0) begin : g_noround
      assign r_full = {nar_in[PW-1], nar_in};
    end else begin : g_round
      localparam logic [RW-1:0] HALF = RW'(1) << (SHIFT - 1);
      logic signed [RW-1:0] sum;
      assign sum    = {nar_in[PW-1], nar_in} + HALF;
      assign r_full = sum >>> SHIFT;
    end
  endgenerate

  // Widen so the narrowing compare always has at least one guard bit above dout
  assign r_ext = XW'(r_full);

`ifdef RECEIVER_MUL_SAT_EN
  localparam logic signed [XW-1:0] MAX_V = XW'({1'b0, {(dout_WIDTH-1){1'b1}}});
  localparam logic signed [XW-1:0] MIN_V = ~MAX_V;

  logic nar_sat;
  logic sat_q;
  logic sat_d;

  // Narrowing with clipping to the signed dout range
  always_comb begin
    nar_sat = 1'b0;
    nar_d   = r_ext[dout_WIDTH-1:0];
    if (r_ext > MAX_V) begin
      nar_d   = MAX_V[dout_WIDTH-1:0];
      nar_sat = 1'b1;
    end else if (r_ext < MIN_V) begin
      nar_d   = MIN_V[dout_WIDTH-1:0];
      nar_sat = 1'b1;
    end
  end

  // Saturation flag travels in the output stage next to its data
  always_comb begin
    sat_d = out_ld ? nar_sat : sat_q;
  end

  // Output saturation flag register
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      sat_q <= 1'b0;
    end else begin
      sat_q <= sat_d;
    end
  end

  assign mul_if.out_sat = sat_q;
`else
  logic unused_r_ext;

  // Narrowing by two's-complement wrap; the guard bits above dout are dropped
  assign nar_d          = r_ext[dout_WIDTH-1:0];
  assign unused_r_ext   = ^r_ext;
  assign mul_if.out_sat = 1'b0;
`endif

  // The output stage captures only real results, so dout holds across bubbles and stalls
  assign out_ld = load[NUM_STAGE-1] && v_in[NUM_STAGE-1];

  // Next-state result: load a new narrowed value or hold the current one
  always_comb begin
    dout_d = out_ld ? nar_d : dout_q;
  end

  // Output result register
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      dout_q <= '0;
    end else begin
      dout_q <= dout_d;
    end
  end

  assign mul_if.dout      = dout_q;
  assign mul_if.out_valid = v_q[NUM_STAGE-1];
  // Report ready during reset so sources never see a spurious stall
  assign mul_if.in_ready  = ap_rst | load[0];

endmodule

// File: tb/tb_receiver_mul_pipe.sv
// tb_receiver_mul_pipe -- scoreboard bench for receiver_mul_pipe.
// Instance A uses the default parameters (2 stages, no shift).
// Instance B uses NUM_STAGE = 3 and SHIFT = 4.
// Honours RECEIVER_MUL_SAT_EN in its reference model.
module tb_receiver_mul_pipe;

  localparam int A_W = 18;
  localparam int B_W = 17;
  localparam int D_W = 34;

  // ---------------- clock / reset ----------------
  logic ap_clk = 1'b0;
  logic ap_rst;
  always #5 ap_clk = ~ap_clk;

  receiver_mul_pipe_if #(.din0_WIDTH(A_W), .din1_WIDTH(B_W), .dout_WIDTH(D_W)) a_if ();
  receiver_mul_pipe_if #(.din0_WIDTH(A_W), .din1_WIDTH(B_W), .dout_WIDTH(D_W)) b_if ();

  receiver_mul_pipe #(
    .din0_WIDTH(A_W), .din1_WIDTH(B_W), .dout_WIDTH(D_W), .NUM_STAGE(2), .SHIFT(0)
  ) u_dut_a (
    .ap_clk (ap_clk),
    .ap_rst (ap_rst),
    .mul_if (a_if.slave)
  );

  receiver_mul_pipe #(
    .din0_WIDTH(A_W), .din1_WIDTH(B_W), .dout_WIDTH(D_W), .NUM_STAGE(3), .SHIFT(4)
  ) u_dut_b (
    .ap_clk (ap_clk),
    .ap_rst (ap_rst),
    .mul_if (b_if.slave)
  );

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: exact product, round half up by the shift, then clip or wrap.
  // The return value is {sat, dout}.
  function automatic logic [D_W:0] model(input longint a, input longint b, input int sh);
    longint p;
    longint r;
    logic [D_W-1:0] d;
    logic s;
`ifdef RECEIVER_MUL_SAT_EN
    longint hi;
    longint lo;
`endif
    p = a * b;
    if (sh > 0) r = (p + (longint'(1) <<< (sh - 1))) >>> sh;
    else        r = p;
    s = 1'b0;
    d = r[D_W-1:0];
`ifdef RECEIVER_MUL_SAT_EN
    hi = (longint'(1) <<< (D_W - 1)) - 1;
    lo = -hi - 1;
    if (r > hi) begin
      d = hi[D_W-1:0];
      s = 1'b1;
    end else if (r < lo) begin
      d = lo[D_W-1:0];
      s = 1'b1;
    end
`endif
    return {s, d};
  endfunction

  function automatic longint rand_op(input int w);
    case ($urandom_range(0, 5))
      0:       return -(longint'(1) <<< (w - 1));
      1:       return (longint'(1) <<< (w - 1)) - 1;
      2:       return 0;
      default: return longint'($urandom_range(0, (1 << w) - 1)) - (longint'(1) <<< (w - 1));
    endcase
  endfunction

  // ---------------- scoreboards / monitors ----------------
  logic [D_W:0] a_exp_q[$];
  logic [D_W:0] b_exp_q[$];
  longint       b_seen[$];
  int           a_occ = 0;
  int           b_occ = 0;
  logic         a_stall_prev = 1'b0;
  logic         b_stall_prev = 1'b0;
  longint       a_prev_dout;
  longint       b_prev_dout;
  logic         a_prev_sat;
  logic         b_prev_sat;
  logic [D_W:0] a_e;
  logic [D_W:0] b_e;

  // Monitor for instance A
  always @(negedge ap_clk) begin
    if (ap_rst) begin
      a_exp_q.delete();
      a_occ = 0;
      a_stall_prev = 1'b0;
      check("a_rst_in_ready", a_if.in_ready, 1);
    end else begin
      // The input may stall only when every stage is full and the output is blocked
      check("a_in_ready", a_if.in_ready, longint'((a_occ < 2) || a_if.out_ready));
      if (a_stall_prev) begin
        check("a_stall_valid", a_if.out_valid, 1);
        check("a_stall_dout", a_if.dout, a_prev_dout);
        check("a_stall_sat", a_if.out_sat, a_prev_sat);
      end
      if (a_if.out_valid && a_if.out_ready) begin
        check("a_out_expected", longint'(a_exp_q.size() != 0), 1);
        if (a_exp_q.size() != 0) begin
          a_e = a_exp_q.pop_front();
          check("a_dout", a_if.dout, $signed(a_e[D_W-1:0]));
          check("a_sat", a_if.out_sat, a_e[D_W]);
          a_occ--;
        end
      end
      if (a_if.in_valid && a_if.in_ready) begin
        a_exp_q.push_back(model(a_if.din0, a_if.din1, 0));
        a_occ++;
      end
      a_stall_prev = a_if.out_valid && !a_if.out_ready;
      a_prev_dout  = a_if.dout;
      a_prev_sat   = a_if.out_sat;
    end
  end

  // Monitor for instance B
  always @(negedge ap_clk) begin
    if (ap_rst) begin
      b_exp_q.delete();
      b_occ = 0;
      b_stall_prev = 1'b0;
      check("b_rst_in_ready", b_if.in_ready, 1);
    end else begin
      check("b_in_ready", b_if.in_ready, longint'((b_occ < 3) || b_if.out_ready));
      if (b_stall_prev) begin
        check("b_stall_valid", b_if.out_valid, 1);
        check("b_stall_dout", b_if.dout, b_prev_dout);
        check("b_stall_sat", b_if.out_sat, b_prev_sat);
      end
      if (b_if.out_valid && b_if.out_ready) begin
        check("b_out_expected", longint'(b_exp_q.size() != 0), 1);
        b_seen.push_back(b_if.dout);
        if (b_exp_q.size() != 0) begin
          b_e = b_exp_q.pop_front();
          check("b_dout", b_if.dout, $signed(b_e[D_W-1:0]));
          check("b_sat", b_if.out_sat, b_e[D_W]);
          b_occ--;
        end
      end
      if (b_if.in_valid && b_if.in_ready) begin
        b_exp_q.push_back(model(b_if.din0, b_if.din1, 4));
        b_occ++;
      end
      b_stall_prev = b_if.out_valid && !b_if.out_ready;
      b_prev_dout  = b_if.dout;
      b_prev_sat   = b_if.out_sat;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic idle_all();
    a_if.in_valid  = 1'b0;
    b_if.in_valid  = 1'b0;
    a_if.out_ready = 1'b1;
    b_if.out_ready = 1'b1;
  endtask

  task automatic random_phase(input int n);
    logic acc_a;
    logic acc_b;
    for (int c = 0; c < n; c++) begin
      @(negedge ap_clk);
      acc_a = a_if.in_valid && a_if.in_ready;
      acc_b = b_if.in_valid && b_if.in_ready;
      step();
      // Offered operands are held until accepted
      if (!a_if.in_valid || acc_a) begin
        a_if.in_valid = ($urandom_range(0, 3) != 0);
        a_if.din0     = A_W'(rand_op(A_W));
        a_if.din1     = B_W'(rand_op(B_W));
      end
      if (!b_if.in_valid || acc_b) begin
        b_if.in_valid = ($urandom_range(0, 3) != 0);
        b_if.din0     = A_W'(rand_op(A_W));
        b_if.din1     = B_W'(rand_op(B_W));
      end
      a_if.out_ready = ($urandom_range(0, 3) != 0);
      b_if.out_ready = ($urandom_range(0, 3) != 0);
    end
  endtask

  // ---------------- test sequence ----------------
  longint exp_sh[4] = '{1, -1, 1, 0};
  int     bubble_pat[4] = '{1, 0, 1, 0};
  int     idx;
  int     stale;

  initial begin
    ap_rst = 1'b1;
    a_if.din0 = '0; a_if.din1 = '0; a_if.in_valid = 1'b0; a_if.out_ready = 1'b0;
    b_if.din0 = '0; b_if.din1 = '0; b_if.in_valid = 1'b0; b_if.out_ready = 1'b0;
    repeat (3) step();
    ap_rst = 1'b0;
    idle_all();
    @(negedge ap_clk);
    check("a_reset_valid", a_if.out_valid, 0);
    check("a_reset_dout", a_if.dout, 0);
    check("a_reset_sat", a_if.out_sat, 0);
    check("b_reset_valid", b_if.out_valid, 0);
    check("b_reset_dout", b_if.dout, 0);
    check("b_reset_sat", b_if.out_sat, 0);

    // Latency and single-pulse valid: -3 * 5 on the default build
    step();
    a_if.din0 = -3; a_if.din1 = 5; a_if.in_valid = 1'b1;
    step();
    a_if.in_valid = 1'b0;
    @(negedge ap_clk);
    check("a_lat_early", a_if.out_valid, 0);
    step();
    @(negedge ap_clk);
    check("a_lat_valid", a_if.out_valid, 1);
    check("a_lat_dout", a_if.dout, -15);
    check("a_lat_sat", a_if.out_sat, 0);
    step();
    @(negedge ap_clk);
    check("a_lat_one_cycle", a_if.out_valid, 0);

    // Overflow corner: (-2^17) * (-2^16) = 2^33
    step();
    a_if.din0 = -131072; a_if.din1 = -65536; a_if.in_valid = 1'b1;
    step();
    a_if.in_valid = 1'b0;
    step();
    @(negedge ap_clk);
    check("a_corner_valid", a_if.out_valid, 1);
`ifdef RECEIVER_MUL_SAT_EN
    check("a_corner_dout", a_if.dout, (longint'(1) <<< 33) - 1);
    check("a_corner_sat", a_if.out_sat, 1);
`else
    check("a_corner_dout", a_if.dout, -(longint'(1) <<< 33));
    check("a_corner_sat", a_if.out_sat, 0);
`endif

    // Round half up with SHIFT = 4: products 21, -21, 8, -8
    step();
    b_seen.delete();
    for (int k = 0; k < 4; k++) begin
      b_if.din0 = A_W'(k == 0 ? 21 : k == 1 ? -21 : k == 2 ? 8 : -8);
      b_if.din1 = 1;
      b_if.in_valid = 1'b1;
      step();
    end
    b_if.in_valid = 1'b0;
    repeat (6) step();
    check("b_round_count", b_seen.size(), 4);
    if (b_seen.size() == 4) begin
      for (int k = 0; k < 4; k++) check("b_round_value", b_seen[k], exp_sh[k]);
    end

    // Stream 1..10 through three stages with the output blocked for cycles 4-7
    b_seen.delete();
    idx = 1;
    for (int c = 1; c <= 40; c++) begin
      b_if.in_valid  = (idx <= 10);
      b_if.din0      = A_W'(idx * 16);
      b_if.din1      = 1;
      b_if.out_ready = !(c >= 4 && c <= 7);
      @(negedge ap_clk);
      if (b_if.in_valid && b_if.in_ready) idx++;
      step();
    end
    b_if.in_valid = 1'b0;
    b_if.out_ready = 1'b1;
    check("b_stream_count", b_seen.size(), 10);
    if (b_seen.size() == 10) begin
      for (int k = 0; k < 10; k++) check("b_stream_order", b_seen[k], k + 1);
    end

    // Bubble collapse: valid 1,0,1,0 while blocked, then two results back-to-back
    a_if.out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      a_if.in_valid = bubble_pat[k][0];
      a_if.din0 = A_W'(7 + k);
      a_if.din1 = 3;
      step();
    end
    a_if.in_valid = 1'b0;
    a_if.out_ready = 1'b1;
    @(negedge ap_clk);
    check("a_bubble_first", a_if.out_valid, 1);
    step();
    @(negedge ap_clk);
    check("a_bubble_second", a_if.out_valid, 1);
    step();
    @(negedge ap_clk);
    check("a_bubble_done", a_if.out_valid, 0);

    // Reset with two results in flight discards them
    step();
    a_if.out_ready = 1'b0;
    a_if.din0 = 11; a_if.din1 = 13; a_if.in_valid = 1'b1;
    step();
    a_if.din0 = -17;
    step();
    a_if.in_valid = 1'b0;
    ap_rst = 1'b1;
    step();
    ap_rst = 1'b0;
    a_if.out_ready = 1'b1;
    @(negedge ap_clk);
    check("a_midrst_valid", a_if.out_valid, 0);
    check("a_midrst_dout", a_if.dout, 0);
    stale = 0;
    for (int k = 0; k < 5; k++) begin
      step();
      @(negedge ap_clk);
      if (a_if.out_valid) stale++;
    end
    check("a_no_stale", stale, 0);

    // Randomized traffic with backpressure on both instances, then drain
    step();
    random_phase(600);
    idle_all();
    repeat (12) step();
    check("a_drained", a_exp_q.size(), 0);
    check("b_drained", b_exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
